// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the 1-to-N packet router.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_DATA,
        FULL_STALL,
        CHECK_PARITY
    } state_t;

    localparam int MAX_CH = 8;
    localparam int HDR_W  = 8;

    function automatic int addr_width(input int num_ch);
        return $clog2(num_ch);
    endfunction

    // The length field starts right above the address field.
    function automatic int len_lsb(input int num_ch);
        return addr_width(num_ch);
    endfunction

    function automatic logic [HDR_W-1:0] hdr_addr(input logic [HDR_W-1:0] hdr, input int num_ch);
        return hdr & HDR_W'((1 << addr_width(num_ch)) - 1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous channel FIFO with flush and a registered read port; a full FIFO
// still accepts a push when a pop happens in the same cycle.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // Pointer MSB distinguishes full from empty when the low bits match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                dout <= mem[rptr[AW-1:0]];
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/router_1xn.sv
// Parametrised 1-to-N packet router: header steers each packet into a channel FIFO.
// Optional idle-read flush of channels is enabled by defining ROUTER_SOFT_RESET_EN.
module router_1xn
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pkt_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        vld_out,
    output logic                     busy,
    output logic                     error
);

    localparam int ADDR_W = addr_width(NUM_CH);

    state_t            state;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] addr;
    logic [HDR_W-1:0]  hdr_field;
    logic              addr_ok;
    logic [DATA_W-1:0] hold;
    logic              hold_is_parity;
    logic [DATA_W-1:0] parity;
    logic [DATA_W-1:0] rx_parity;
    logic [DATA_W-1:0] wdata;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] can_push;
    logic [NUM_CH-1:0] flush;
    logic              abort;

    assign hdr_field = hdr_addr(HDR_W'(data_in), NUM_CH);
    assign addr_ok   = (hdr_field < HDR_W'(NUM_CH));
    assign addr      = hdr_field[ADDR_W-1:0];
    assign vld_out   = ~empty;
    // A full FIFO that is being read this cycle still takes a word.
    assign can_push  = ~full | read_enb;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_fifo #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .push (push[i]),
            .pop  (read_enb[i]),
            .flush(flush[i]),
            .din  (wdata),
            .dout (data_out[i*DATA_W +: DATA_W]),
            .full (full[i]),
            .empty(empty[i])
        );
    end

`ifdef ROUTER_SOFT_RESET_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_idle
        logic [CNT_W-1:0] idle_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                idle_cnt <= '0;
            end else if (read_enb[i] || idle_cnt == CNT_W'(TIMEOUT)) begin
                idle_cnt <= '0;
            end else if (vld_out[i]) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
        end

        assign flush[i] = (idle_cnt == CNT_W'(TIMEOUT));
    end

    assign abort = (state != DECODE) && flush[target];
`else
    logic unused_timeout;

    assign flush          = '0;
    assign abort          = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        push  = '0;
        wdata = data_in;
        case (state)
            DECODE: begin
                if (pkt_valid && addr_ok && empty[addr]) begin
                    push[addr] = 1'b1;
                end
            end
            WAIT_EMPTY: begin
                if (empty[target]) begin
                    push[target] = 1'b1;
                    wdata        = hold;
                end
            end
            LOAD_DATA: begin
                if (can_push[target]) begin
                    push[target] = 1'b1;
                end
            end
            FULL_STALL: begin
                if (can_push[target]) begin
                    push[target] = 1'b1;
                    wdata        = hold;
                end
            end
            default: ;
        endcase
    end

    // The parity word is never folded into the accumulator; it is compared against it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= DECODE;
            target         <= '0;
            hold           <= '0;
            hold_is_parity <= 1'b0;
            parity         <= '0;
            rx_parity      <= '0;
            busy           <= 1'b0;
            error          <= 1'b0;
        end else if (abort) begin
            state <= DECODE;
            busy  <= 1'b0;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid && addr_ok) begin
                        target <= addr;
                        if (empty[addr]) begin
                            parity <= data_in;
                            error  <= 1'b0;
                            state  <= LOAD_DATA;
                            busy   <= 1'b0;
                        end else begin
                            hold  <= data_in;
                            state <= WAIT_EMPTY;
                            busy  <= 1'b1;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (empty[target]) begin
                        parity <= hold;
                        error  <= 1'b0;
                        state  <= LOAD_DATA;
                        busy   <= 1'b0;
                    end
                end
                LOAD_DATA: begin
                    if (pkt_valid) begin
                        parity <= parity ^ data_in;
                    end else begin
                        rx_parity <= data_in;
                    end
                    if (can_push[target]) begin
                        if (!pkt_valid) begin
                            state <= CHECK_PARITY;
                            busy  <= 1'b1;
                        end
                    end else begin
                        hold           <= data_in;
                        hold_is_parity <= !pkt_valid;
                        state          <= FULL_STALL;
                        busy           <= 1'b1;
                    end
                end
                FULL_STALL: begin
                    if (can_push[target]) begin
                        if (hold_is_parity) begin
                            state <= CHECK_PARITY;
                        end else begin
                            state <= LOAD_DATA;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHECK_PARITY: begin
                    error <= (rx_parity != parity);
                    state <= DECODE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= DECODE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_1xn.sv
// Directed self-checking bench for router_1xn (NUM_CH=3, DATA_W=8, DEPTH=16).
module tb_router_1xn;

    logic        clk;
    logic        reset;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  vld_out;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [7:0] pkt_q[$];
    logic [7:0] exp_q[$];

    router_1xn #(
        .DATA_W (8),
        .NUM_CH (3),
        .DEPTH  (16),
        .TIMEOUT(30)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .read_enb (read_enb),
        .data_out (data_out),
        .vld_out  (vld_out),
        .busy     (busy),
        .error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Header, n payload words base + k*step, then the xor parity word (optionally corrupted).
    task automatic build_pkt(input logic [7:0] hdr, input int n, input logic [7:0] base,
                             input logic [7:0] step, input logic corrupt);
        logic [7:0] par;
        logic [7:0] w;
        pkt_q = {};
        pkt_q.push_back(hdr);
        par = hdr;
        for (int k = 0; k < n; k++) begin
            w = base + 8'(k) * step;
            pkt_q.push_back(w);
            par ^= w;
        end
        if (corrupt) par ^= 8'h01;
        pkt_q.push_back(par);
    endtask

    // A word is consumed at the rising edge where busy was low.
    task automatic send_word(input logic [7:0] w, input logic v, output int stalls);
        logic was_busy;
        bit   taken;
        taken  = 0;
        stalls = 0;
        data_in   = w;
        pkt_valid = v;
        for (int g = 0; g < 100 && !taken; g++) begin
            was_busy = busy;
            @(posedge clk);
            if (!was_busy) taken = 1;
            else stalls++;
            @(negedge clk);
        end
        if (!taken) begin
            total++; bad++;
            $display("[TB] FAIL send_timeout: word %h not accepted, busy=%b required 0", w, busy);
        end
    endtask

    task automatic send_pkt(output int stalls);
        int s;
        stalls = 0;
        for (int k = 0; k < pkt_q.size(); k++) begin
            send_word(pkt_q[k], (k != pkt_q.size() - 1), s);
            stalls += s;
        end
        pkt_valid = 1'b0;
        data_in   = '0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        pkt_valid = 1'b0;
        data_in   = '0;
        read_enb  = '0;
        repeat (2) @(negedge clk);
        total++; if (data_out !== 24'h0) begin bad++; $display("[TB] FAIL rst_data_out: got %h required %h", data_out, 24'h0); end
        total++; if (vld_out !== 3'b000) begin bad++; $display("[TB] FAIL rst_vld_out: got %b required %b", vld_out, 3'b000); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL rst_error: got %b required 0", error); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_packet;
        int stalls;
        build_pkt(8'h38, 14, 8'h0B, 8'h25, 1'b0);
        exp_q = pkt_q;
        send_pkt(stalls);
        total++; if (stalls != 0) begin bad++; $display("[TB] FAIL t1_stalls: got %0d required 0", stalls); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_busy_chk: got %b required 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t1_busy_idle: got %b required 0", busy); end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t1_error: got %b required 0", error); end
        total++; if (vld_out !== 3'b001) begin bad++; $display("[TB] FAIL t1_vld: got %b required %b", vld_out, 3'b001); end
        @(negedge clk);
        read_enb = 3'b001;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            total++; if (data_out[7:0] !== exp_q[k]) begin bad++; $display("[TB] FAIL t1_word%0d: got %h required %h", k, data_out[7:0], exp_q[k]); end
        end
        @(negedge clk);
        total++; if (data_out[7:0] !== exp_q[15]) begin bad++; $display("[TB] FAIL t1_empty_hold: got %h required %h", data_out[7:0], exp_q[15]); end
        total++; if (vld_out[0] !== 1'b0) begin bad++; $display("[TB] FAIL t1_vld_fall: got %b required 0", vld_out[0]); end
        read_enb = '0;
    endtask

    task automatic test_full_stall;
        int  stalls;
        int  c;
        bit  seen;
        build_pkt(8'h41, 16, 8'hC0, 8'h01, 1'b0);
        exp_q = pkt_q;
        fork
            send_pkt(stalls);
            begin
                seen = 0;
                for (c = 1; c <= 40; c++) begin
                    @(negedge clk);
                    if (busy) begin seen = 1; break; end
                end
                total++; if (!seen || c != 17) begin bad++; $display("[TB] FAIL t2_stall_cycle: got %0d required 17", c); end
                repeat (2) @(negedge clk);
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL t2_busy_stall: got %b required 1", busy); end
                total++; if (vld_out[1] !== 1'b1) begin bad++; $display("[TB] FAIL t2_vld: got %b required 1", vld_out[1]); end
                read_enb = 3'b010;
                for (int k = 0; k < 18; k++) begin
                    @(negedge clk);
                    total++; if (data_out[15:8] !== exp_q[k]) begin bad++; $display("[TB] FAIL t2_word%0d: got %h required %h", k, data_out[15:8], exp_q[k]); end
                end
                read_enb = '0;
                total++; if (vld_out[1] !== 1'b0) begin bad++; $display("[TB] FAIL t2_vld_fall: got %b required 0", vld_out[1]); end
            end
        join
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t2_error: got %b required 0", error); end
    endtask

    task automatic test_parity_error;
        int s;
        build_pkt(8'h0E, 3, 8'h5C, 8'h87, 1'b1);
        send_pkt(s);
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t3_error_early: got %b required 0", error); end
        @(negedge clk);
        total++; if (error !== 1'b1) begin bad++; $display("[TB] FAIL t3_error_set: got %b required 1", error); end
        // Zero-length packet to ch0: its header clears error, its parity is correct.
        send_word(8'h00, 1'b1, s);
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t3_error_clear: got %b required 0", error); end
        send_word(8'h00, 1'b0, s);
        pkt_valid = 1'b0;
        @(negedge clk);
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t3_zero_len_error: got %b required 0", error); end
        read_enb = 3'b001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (data_out[7:0] !== 8'h00) begin bad++; $display("[TB] FAIL t3_zero_word%0d: got %h required 00", k, data_out[7:0]); end
        end
        read_enb = '0;
        total++; if (vld_out[0] !== 1'b0) begin bad++; $display("[TB] FAIL t3_ch0_vld: got %b required 0", vld_out[0]); end
    endtask

    task automatic test_bad_addr;
        int s;
        send_word(8'h07, 1'b1, s);
        pkt_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t4_busy: got %b required 0", busy); end
        @(negedge clk);
        total++; if (vld_out[1:0] !== 2'b00) begin bad++; $display("[TB] FAIL t4_vld: got %b required 00", vld_out[1:0]); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t4_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_wait_empty;
        int         stalls;
        logic [7:0] old_q[$];
        old_q = {8'h0E, 8'h5C, 8'hE3, 8'h6A, 8'hDA};
        build_pkt(8'h06, 1, 8'h3C, 8'h00, 1'b0);
        exp_q = pkt_q;
        fork
            send_pkt(stalls);
            begin
                @(negedge clk);
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL t5_busy_wait: got %b required 1", busy); end
                repeat (3) @(negedge clk);
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL t5_busy_hold: got %b required 1", busy); end
                read_enb = 3'b100;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    total++; if (data_out[23:16] !== old_q[k]) begin bad++; $display("[TB] FAIL t5_old%0d: got %h required %h", k, data_out[23:16], old_q[k]); end
                end
                read_enb = '0;
                total++; if (vld_out[2] !== 1'b0) begin bad++; $display("[TB] FAIL t5_drained: got %b required 0", vld_out[2]); end
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL t5_busy_last: got %b required 1", busy); end
                @(negedge clk);
                total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_busy_release: got %b required 0", busy); end
                total++; if (vld_out[2] !== 1'b1) begin bad++; $display("[TB] FAIL t5_hdr_written: got %b required 1", vld_out[2]); end
            end
        join
        read_enb = 3'b100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (data_out[23:16] !== exp_q[k]) begin bad++; $display("[TB] FAIL t5_new%0d: got %h required %h", k, data_out[23:16], exp_q[k]); end
        end
        read_enb = '0;
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t5_error: got %b required 0", error); end
    endtask

    task automatic test_reset_mid_packet;
        int s;
        send_word(8'h11, 1'b1, s);
        send_word(8'hA1, 1'b1, s);
        send_word(8'hA2, 1'b1, s);
        #2 reset = 1'b1;
        #1;
        total++; if (vld_out !== 3'b000) begin bad++; $display("[TB] FAIL t6_rst_vld: got %b required 000", vld_out); end
        total++; if (data_out !== 24'h0) begin bad++; $display("[TB] FAIL t6_rst_data: got %h required 0", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_rst_busy: got %b required 0", busy); end
        pkt_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        build_pkt(8'h05, 1, 8'h77, 8'h00, 1'b0);
        exp_q = pkt_q;
        send_pkt(s);
        @(negedge clk);
        read_enb = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (data_out[15:8] !== exp_q[k]) begin bad++; $display("[TB] FAIL t6_word%0d: got %h required %h", k, data_out[15:8], exp_q[k]); end
        end
        read_enb = '0;
        total++; if (vld_out[1] !== 1'b0) begin bad++; $display("[TB] FAIL t6_vld_fall: got %b required 0", vld_out[1]); end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL t6_error: got %b required 0", error); end
    endtask

`ifdef ROUTER_SOFT_RESET_EN
    task automatic test_soft_reset;
        int s;
        build_pkt(8'h00, 0, 8'h00, 8'h00, 1'b0);
        send_pkt(s);
        repeat (10) @(negedge clk);
        total++; if (vld_out[0] !== 1'b1) begin bad++; $display("[TB] FAIL t7_before: got %b required 1", vld_out[0]); end
        repeat (30) @(negedge clk);
        total++; if (vld_out[0] !== 1'b0) begin bad++; $display("[TB] FAIL t7_flushed: got %b required 0", vld_out[0]); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        pkt_valid = 1'b0;
        data_in   = '0;
        read_enb  = '0;
        test_reset();
        test_single_packet();
        test_full_stall();
        test_parity_error();
        test_bad_addr();
        test_wait_empty();
        test_reset_mid_packet();
`ifdef ROUTER_SOFT_RESET_EN
        test_soft_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
